// File: rtl/tlb_miss_sequencer.sv
// TLB miss sequencer: round-robin arbitration of two translation ports, TLB lookup, victim write-back, PT fetch and fill.
// Optional PT wait timeout is enabled by defining TLB_SEQ_TIMEOUT_EN.
module tlb_miss_sequencer #(
  parameter int VA_WIDTH       = 14,
  parameter int PA_WIDTH       = 10,
  parameter int OFFSET_BITS    = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [1:0]                      req_valid,
  output logic [1:0]                      req_ready,
  input  logic [VA_WIDTH-1:0]             req_va0,
  input  logic [VA_WIDTH-1:0]             req_va1,
  input  logic                            req_write1,
  output logic [1:0]                      resp_valid,
  output logic [PA_WIDTH-1:0]             resp_pa,
  output logic                            resp_fault,
  output logic                            tlb_lookup,
  output logic [VA_WIDTH-OFFSET_BITS-1:0] tlb_vpn,
  input  logic                            tlb_hit,
  input  logic [PA_WIDTH-OFFSET_BITS-1:0] tlb_ppn,
  input  logic                            tlb_victim_valid,
  input  logic                            tlb_victim_dirty,
  input  logic                            tlb_victim_ref,
  input  logic [VA_WIDTH-OFFSET_BITS-1:0] tlb_victim_vpn,
  output logic                            tlb_touch,
  output logic                            tlb_mark_dirty,
  output logic                            tlb_fill,
  output logic [PA_WIDTH-OFFSET_BITS-1:0] tlb_fill_ppn,
  output logic                            tlb_fill_dirty,
  output logic                            tlb_fill_ref,
  output logic                            pt_req,
  output logic                            pt_write,
  output logic [VA_WIDTH-OFFSET_BITS-1:0] pt_vpn,
  output logic                            pt_dirty_wb,
  output logic                            pt_ref_wb,
  input  logic                            pt_done,
  input  logic                            pt_page_fault,
  input  logic [PA_WIDTH-OFFSET_BITS-1:0] pt_ppn,
  input  logic                            pt_dirty,
  input  logic                            pt_ref
);
  localparam int VPN_W = VA_WIDTH - OFFSET_BITS;
  localparam int PPN_W = PA_WIDTH - OFFSET_BITS;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_WRITEBACK = 3'd2;
  localparam logic [2:0] S_FETCH     = 3'd3;
  localparam logic [2:0] S_FILL      = 3'd4;
  localparam logic [2:0] S_RESPOND   = 3'd5;

  logic [2:0]          state, state_nxt;
  logic                last_grant, port, fault;
  logic [1:0]          grant;
  logic                grant_port;
  logic [VA_WIDTH-1:0] va;
  logic                write;
  logic [VPN_W-1:0]    victim_vpn;
  logic                victim_ref;
  logic [PPN_W-1:0]    ppn;
  logic                fetched_dirty;
  logic                timed_out;
  logic                pt_wait;
  logic [VPN_W-1:0]    req_vpn;

  assign req_vpn = va[VA_WIDTH-1:OFFSET_BITS];
  assign pt_wait = (state == S_WRITEBACK) || (state == S_FETCH);

  // On a tie the port not granted last wins.
  always_comb begin
    grant      = 2'b00;
    grant_port = 1'b0;
    if (req_valid == 2'b11) begin
      grant_port = ~last_grant;
      grant      = last_grant ? 2'b01 : 2'b10;
    end else if (req_valid[0]) begin
      grant = 2'b01;
    end else if (req_valid[1]) begin
      grant      = 2'b10;
      grant_port = 1'b1;
    end
  end

`ifdef TLB_SEQ_TIMEOUT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   wait_cnt <= 8'd0;
    else if (state_nxt != state) wait_cnt <= 8'd0;
    else if (pt_wait)            wait_cnt <= wait_cnt + 8'd1;
  end

  // pt_done in the final cycle still wins over the timeout.
  assign timed_out = pt_wait && (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) && !pt_done;
`else
  assign timed_out = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (grant != 2'b00) state_nxt = S_LOOKUP;
      S_LOOKUP:    if (tlb_hit) state_nxt = S_RESPOND;
                   else if (tlb_victim_valid && tlb_victim_dirty) state_nxt = S_WRITEBACK;
                   else state_nxt = S_FETCH;
      S_WRITEBACK: if (pt_done) state_nxt = S_FETCH;
                   else if (timed_out) state_nxt = S_RESPOND;
      S_FETCH:     if (pt_done) state_nxt = pt_page_fault ? S_RESPOND : S_FILL;
                   else if (timed_out) state_nxt = S_RESPOND;
      S_FILL:      state_nxt = S_RESPOND;
      S_RESPOND:   state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      port       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && grant != 2'b00) begin
        last_grant <= grant_port;
        port       <= grant_port;
        fault      <= 1'b0;
      end
      if ((state == S_FETCH && pt_done && pt_page_fault) || timed_out) fault <= 1'b1;
    end
  end

  // Transaction payload; only qualified by state, so no reset is needed.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && grant != 2'b00) begin
      va    <= grant_port ? req_va1 : req_va0;
      write <= grant_port & req_write1;
    end
    if (state == S_LOOKUP) begin
      if (tlb_hit) ppn <= tlb_ppn;
      victim_vpn <= tlb_victim_vpn;
      victim_ref <= tlb_victim_ref;
    end
    if (state == S_FETCH && pt_done) begin
      ppn           <= pt_ppn;
      fetched_dirty <= pt_dirty;
    end
  end

  assign req_ready      = (state == S_IDLE && !reset) ? grant : 2'b00;
  assign tlb_lookup     = (state == S_LOOKUP);
  assign tlb_vpn        = (state == S_LOOKUP || state == S_FILL) ? req_vpn : '0;
  assign tlb_touch      = (state == S_LOOKUP) && tlb_hit;
  assign tlb_mark_dirty = (state == S_LOOKUP) && tlb_hit && write;
  assign tlb_fill       = (state == S_FILL);
  assign tlb_fill_ppn   = (state == S_FILL) ? ppn : '0;
  assign tlb_fill_dirty = (state == S_FILL) && (fetched_dirty || write);
  assign tlb_fill_ref   = (state == S_FILL);
  assign pt_req         = pt_wait;
  assign pt_write       = (state == S_WRITEBACK);
  assign pt_vpn         = (state == S_WRITEBACK) ? victim_vpn : (state == S_FETCH) ? req_vpn : '0;
  assign pt_dirty_wb    = (state == S_WRITEBACK);
  assign pt_ref_wb      = (state == S_WRITEBACK) && victim_ref;
  assign resp_valid     = (state == S_RESPOND) ? (port ? 2'b10 : 2'b01) : 2'b00;
  assign resp_fault     = (state == S_RESPOND) && fault;
  assign resp_pa        = (state == S_RESPOND && !fault) ? {ppn, va[OFFSET_BITS-1:0]} : '0;

  // The fetched reference bit is not stored: a filled entry is always referenced.
  logic unused;
  assign unused = pt_ref;
endmodule

// File: tb/tb_tlb_miss_sequencer.sv
// Scoreboard bench for tlb_miss_sequencer: directed transactions push expected responses, a monitor checks them.
module tb_tlb_miss_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, resp_valid;
  logic [13:0] req_va0, req_va1;
  logic        req_write1;
  logic [9:0]  resp_pa;
  logic        resp_fault, tlb_lookup, tlb_hit;
  logic [5:0]  tlb_vpn, tlb_victim_vpn, pt_vpn;
  logic [1:0]  tlb_ppn, tlb_fill_ppn, pt_ppn;
  logic        tlb_victim_valid, tlb_victim_dirty, tlb_victim_ref;
  logic        tlb_touch, tlb_mark_dirty, tlb_fill, tlb_fill_dirty, tlb_fill_ref;
  logic        pt_req, pt_write, pt_dirty_wb, pt_ref_wb;
  logic        pt_done, pt_page_fault, pt_dirty, pt_ref;

  tlb_miss_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_va0(req_va0), .req_va1(req_va1), .req_write1(req_write1),
    .resp_valid(resp_valid), .resp_pa(resp_pa), .resp_fault(resp_fault),
    .tlb_lookup(tlb_lookup), .tlb_vpn(tlb_vpn), .tlb_hit(tlb_hit), .tlb_ppn(tlb_ppn),
    .tlb_victim_valid(tlb_victim_valid), .tlb_victim_dirty(tlb_victim_dirty),
    .tlb_victim_ref(tlb_victim_ref), .tlb_victim_vpn(tlb_victim_vpn),
    .tlb_touch(tlb_touch), .tlb_mark_dirty(tlb_mark_dirty), .tlb_fill(tlb_fill),
    .tlb_fill_ppn(tlb_fill_ppn), .tlb_fill_dirty(tlb_fill_dirty), .tlb_fill_ref(tlb_fill_ref),
    .pt_req(pt_req), .pt_write(pt_write), .pt_vpn(pt_vpn), .pt_dirty_wb(pt_dirty_wb),
    .pt_ref_wb(pt_ref_wb), .pt_done(pt_done), .pt_page_fault(pt_page_fault),
    .pt_ppn(pt_ppn), .pt_dirty(pt_dirty), .pt_ref(pt_ref)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         port;
    logic [9:0] pa;
    logic       fault;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Monitor: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (resp_valid !== 2'b00) begin
      if (q.size() == 0) begin
        chk("unexpected_resp", {62'd0, resp_valid}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("resp_port", {62'd0, resp_valid}, (e.port == 1) ? 64'd2 : 64'd1);
        chk("resp_pa", {54'd0, resp_pa}, {54'd0, e.pa});
        chk("resp_fault", {63'd0, resp_fault}, {63'd0, e.fault});
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clk); #3; k++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic push(input int p, input logic [9:0] pa, input logic f, input int at);
    exp_t e;
    e.port = p; e.pa = pa; e.fault = f; e.cyc = at;
    q.push_back(e);
  endtask

  // Returns the accept cycle, or -1 if no grant arrived.
  task automatic wait_accept(input int p, output int acc);
    int k = 0;
    #1;
    while (req_ready == 2'b00 && k < 20) begin
      @(negedge clk); #1; k++;
    end
    chk("accept", {62'd0, req_ready}, (p == 0) ? 64'd1 : 64'd2);
    acc = (req_ready == 2'b00) ? -1 : cyc;
  endtask

  task automatic run_txn(input int p, input logic [13:0] va, input logic wr, input logic hit,
                         input logic [1:0] tppn, input logic vvalid, input logic vdirty,
                         input logic [5:0] vvpn, input logic vref, input int m, input int n,
                         input logic [1:0] pppn, input logic pdirty, input logic pf,
                         input logic [9:0] exp_pa, input int exp_lat,
                         input logic exp_mark_dirty, input logic exp_fill_dirty);
    int acc;
    @(negedge clk);
    if (p == 0) req_va0 = va; else req_va1 = va;
    req_write1 = wr;
    req_valid = (p == 0) ? 2'b01 : 2'b10;
    tlb_hit = hit; tlb_ppn = tppn;
    tlb_victim_valid = vvalid; tlb_victim_dirty = vdirty;
    tlb_victim_vpn = vvpn; tlb_victim_ref = vref;
    wait_accept(p, acc);
    if (acc >= 0) begin
      push(p, exp_pa, pf, acc + exp_lat);
      @(negedge clk); req_valid = 2'b00; #1;
      chk("lookup", {tlb_lookup, tlb_vpn}, {1'b1, va[13:8]});
      if (hit) begin
        chk("touch", {tlb_touch, tlb_mark_dirty}, {1'b1, exp_mark_dirty});
      end else begin
        chk("no_touch", {63'd0, tlb_touch}, 64'd0);
        if (vvalid && vdirty) begin
          for (int i = 0; i < m; i++) begin
            @(negedge clk);
            pt_done = (i == m - 1);
            pt_page_fault = 1'b1;
            #1;
            if (i == 0)
              chk("writeback", {pt_req, pt_write, pt_vpn, pt_dirty_wb, pt_ref_wb},
                  {1'b1, 1'b1, vvpn, 1'b1, vref});
          end
        end
        for (int i = 0; i < n; i++) begin
          @(negedge clk);
          pt_done = (i == n - 1);
          pt_page_fault = pf && (i == n - 1);
          pt_ppn = pppn; pt_dirty = pdirty;
          #1;
          if (i == 0) chk("fetch", {pt_req, pt_write, pt_vpn}, {1'b1, 1'b0, va[13:8]});
        end
        @(negedge clk);
        pt_done = 1'b0; pt_page_fault = 1'b0;
        #1;
        if (!pf)
          chk("fill", {tlb_fill, tlb_vpn, tlb_fill_ppn, tlb_fill_dirty, tlb_fill_ref},
              {1'b1, va[13:8], pppn, exp_fill_dirty, 1'b1});
        else
          chk("no_fill", {62'd0, tlb_fill, pt_req}, 64'd0);
      end
    end else begin
      req_valid = 2'b00;
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int acc;
    int k;
    reset = 1'b1; req_valid = 2'b00; req_va0 = '0; req_va1 = '0; req_write1 = 1'b0;
    tlb_hit = 1'b0; tlb_ppn = '0; tlb_victim_valid = 1'b0; tlb_victim_dirty = 1'b0;
    tlb_victim_ref = 1'b0; tlb_victim_vpn = '0;
    pt_done = 1'b0; pt_page_fault = 1'b0; pt_ppn = '0; pt_dirty = 1'b0; pt_ref = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_a", {req_ready, resp_valid, resp_pa, resp_fault, tlb_lookup, tlb_vpn}, 64'd0);
    chk("reset_out_b", {tlb_touch, tlb_mark_dirty, tlb_fill, tlb_fill_ppn, tlb_fill_dirty,
                        tlb_fill_ref, pt_req, pt_write, pt_vpn, pt_dirty_wb, pt_ref_wb}, 64'd0);
    @(negedge clk); reset = 1'b0;

    // port 1 lw hit
    run_txn(1, 14'h0312, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 6'h00, 1'b0, 0, 0, 2'b00, 1'b0, 1'b0,
            10'h212, 2, 1'b0, 1'b0);
    // port 0 clean miss, PT done after 3 cycles
    run_txn(0, 14'h0504, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 6'h00, 1'b0, 0, 3, 2'b01, 1'b0, 1'b0,
            10'h104, 6, 1'b0, 1'b0);
    // port 1 sw miss, dirty victim 2A written back over 2 cycles
    run_txn(1, 14'h0A7F, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 6'h2A, 1'b1, 2, 1, 2'b11, 1'b0, 1'b0,
            10'h37F, 6, 1'b0, 1'b1);
    // port 0 page fault, valid but clean victim
    run_txn(0, 14'h3FC0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 6'h11, 1'b1, 0, 2, 2'b10, 1'b0, 1'b1,
            10'h000, 4, 1'b0, 1'b0);
    // port 1 sw hit marks dirty
    run_txn(1, 14'h1155, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 6'h00, 1'b0, 0, 0, 2'b00, 1'b0, 1'b0,
            10'h155, 2, 1'b1, 1'b0);
    // port 0 ignores req_write1
    run_txn(0, 14'h2233, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 6'h00, 1'b0, 0, 0, 2'b00, 1'b0, 1'b0,
            10'h033, 2, 1'b0, 1'b0);
    // port 0 dirty miss with fetched dirty page
    run_txn(0, 14'h0789, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 6'h15, 1'b0, 1, 1, 2'b10, 1'b1, 1'b0,
            10'h289, 5, 1'b0, 1'b1);

    // reset during FETCH discards the request
    @(negedge clk);
    req_va0 = 14'h0504; req_valid = 2'b01; tlb_hit = 1'b0; tlb_victim_valid = 1'b0;
    wait_accept(0, acc);
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); #1;
    chk("pre_reset_fetch", {63'd0, pt_req}, 64'd1);
    reset = 1'b1; #1;
    chk("reset_drop", {59'd0, pt_req, resp_valid, tlb_lookup, tlb_fill}, 64'd0);
    @(negedge clk); reset = 1'b0;
    repeat (6) @(negedge clk);
    #3;
    chk("reset_no_resp", q.size(), 0);

    // both ports held: grants alternate 0,1,0,1 starting from reset
    @(negedge clk);
    req_va0 = 14'h0010; req_va1 = 14'h0120; req_write1 = 1'b0;
    tlb_hit = 1'b1; tlb_ppn = 2'b11; req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      k = 0;
      #1;
      while (req_ready == 2'b00 && k < 20) begin
        @(negedge clk); #1; k++;
      end
      chk("rr_grant", {62'd0, req_ready}, (g % 2 == 0) ? 64'd1 : 64'd2);
      push(g % 2, (g % 2 == 0) ? 10'h310 : 10'h320, 1'b0, cyc + 2);
      @(negedge clk);
    end
    req_valid = 2'b00;
    drain();

`ifdef TLB_SEQ_TIMEOUT_EN
    // PT never answers: fault 64 cycles after FETCH entry
    @(negedge clk);
    req_va1 = 14'h2C01; req_write1 = 1'b0; req_valid = 2'b10;
    tlb_hit = 1'b0; tlb_victim_valid = 1'b0; pt_done = 1'b0;
    wait_accept(1, acc);
    push(1, 10'h000, 1'b1, acc + 2 + 64);
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); #1;
    chk("timeout_fetch", {63'd0, pt_req}, 64'd1);
    drain();
`endif

    chk("final_queue", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tlb_miss_sequencer.md
# tlb_miss_sequencer

Sequential controller that sits between two CPU translation requesters (port 0: instruction fetch, read-only; port 1: data, lw/sw) and the shared 4-entry TLB plus the page table (PT). It arbitrates round-robin, issues one TLB lookup at a time, and on a miss runs the eviction write-back, PT fetch and TLB fill. It then returns one physical address, or a fault, to the granted port.

## Interface
Parameters:
- VA_WIDTH, 14, virtual address width
- PA_WIDTH, 10, physical address width
- OFFSET_BITS, 8, page offset width; VPN = VA_WIDTH-OFFSET_BITS (6), PPN = PA_WIDTH-OFFSET_BITS (2)
- TIMEOUT_CYCLES, 64, PT wait limit (only with TLB_SEQ_TIMEOUT_EN)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  2  per-port request
- req_ready  out  2  one-hot accept pulse
- req_va0, req_va1  in  VA_WIDTH  per-port virtual address
- req_write1  in  1  port 1: 1=sw, 0=lw (port 0 always read)
- resp_valid  out  2  one-hot, one-cycle response pulse
- resp_pa  out  PA_WIDTH  {ppn, offset}
- resp_fault  out  1  page fault / timeout, qualifies resp_valid
- tlb_lookup  out  1  lookup strobe
- tlb_vpn  out  VPN  lookup/fill VPN
- tlb_hit, tlb_ppn  in  1, PPN  combinational lookup result
- tlb_victim_valid, tlb_victim_dirty, tlb_victim_ref  in  1 each  LRU victim state
- tlb_victim_vpn  in  VPN  LRU victim tag
- tlb_touch, tlb_mark_dirty  out  1 each  LRU update / set dirty on hit
- tlb_fill  out  1  write entry into the victim slot
- tlb_fill_ppn  out  PPN; tlb_fill_dirty, tlb_fill_ref  out  1 each
- pt_req, pt_write  out  1 each  PT request; 1=write-back, 0=read
- pt_vpn  out  VPN
- pt_dirty_wb, pt_ref_wb  out  1 each  write-back bits
- pt_done, pt_page_fault  in  1 each
- pt_ppn  in  PPN; pt_dirty, pt_ref  in  1 each  fetched translation

## Operation
- States: IDLE, LOOKUP, WRITEBACK, FETCH, FILL, RESPOND.
- IDLE:
  - Grant a pending port. On a tie, grant the port not granted last. last_grant resets to 1, so port 0 wins the first tie.
  - Pulse req_ready for the granted port and latch VA, write flag and port ID.
  - Next state: LOOKUP.
- LOOKUP:
  - tlb_lookup=1 for one cycle, tlb_vpn=latched VPN.
  - On tlb_hit: latch PA={tlb_ppn, offset}, pulse tlb_touch, set tlb_mark_dirty=write, go to RESPOND.
  - On a miss: latch the victim fields. Go to WRITEBACK if victim valid & dirty, else go to FETCH.
- WRITEBACK: pt_req=1, pt_write=1, pt_vpn=victim VPN, pt_dirty_wb=1, pt_ref_wb=victim ref. Hold until pt_done, then go to FETCH.
- FETCH: pt_req=1, pt_write=0, pt_vpn=request VPN. Hold until pt_done.
  - pt_page_fault=1: set fault, go to RESPOND (no fill).
  - Otherwise latch pt_ppn, go to FILL.
- FILL: tlb_fill=1 for one cycle with tlb_vpn=request VPN, tlb_fill_ppn=pt_ppn, tlb_fill_dirty=pt_dirty|write, tlb_fill_ref=1. Then go to RESPOND.
- RESPOND: pulse resp_valid[port] with resp_pa and resp_fault, then go to IDLE. A fault response drives resp_pa=0.
- pt_done is ignored outside WRITEBACK/FETCH. pt_page_fault is ignored in WRITEBACK.
- A new request is never accepted before RESPOND completes.

## Timing
- All outputs are registered or decoded from state. Reset value of every output is 0, and the state resets to IDLE.
- Hit: accept in cycle 0, LOOKUP in cycle 1, resp_valid in cycle 2.
- Clean miss: cycles 0 and 1 as above, FETCH lasts N≥1 cycles, then FILL, then RESPOND. resp_valid arrives at 3+N.
- Dirty miss: adds M≥1 WRITEBACK cycles, so resp_valid arrives at 3+M+N.
- pt_done high in the first cycle of WRITEBACK/FETCH counts, so the minimum state duration is 1 cycle.
- Back-to-back: the next accept is possible in the cycle after RESPOND.
- Reset mid-operation: all outputs, including pt_req, drop asynchronously. The in-flight request is discarded with no response.
- A requester holding req_valid keeps its VA stable until req_ready.

## Configuration
- TLB_SEQ_TIMEOUT_EN defined:
  - An 8-bit counter runs in WRITEBACK/FETCH and clears on state entry.
  - When the count reaches TIMEOUT_CYCLES-1 without pt_done, go to RESPOND with resp_fault=1 and pt_req deasserted.
- Undefined: no counter; WRITEBACK/FETCH wait indefinitely.

## Test plan
- Port 1 lw VA=14'h0312, tlb_hit=1, tlb_ppn=2'b10 -> resp_valid=2'b10 two cycles after accept, resp_pa=10'h212, tlb_touch=1, tlb_mark_dirty=0.
- Port 0 VA=14'h0504, miss, victim clean, pt_done after 3 cycles with pt_ppn=2'b01, pt_dirty=0 -> pt_write=0, pt_vpn=6'h05; tlb_fill=1 with fill_ref=1, fill_dirty=0; resp_pa=10'h104 at cycle 6.
- Port 1 sw miss, victim valid/dirty with vpn=6'h2A, ref=1 -> WRITEBACK: pt_write=1, pt_vpn=6'h2A, pt_dirty_wb=1, pt_ref_wb=1; then FETCH; fill_dirty=1.
- Miss with pt_page_fault=1 -> resp_fault=1, resp_pa=0, no tlb_fill pulse.
- Both ports valid continuously -> grants alternate 0,1,0,1. Asserting reset during FETCH drops pt_req the same cycle and produces no resp_valid.
- With TLB_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=64, pt_done never asserted -> resp_fault=1 exactly 64 cycles after FETCH entry.
